// File: rtl/t08_wb_mem_slave.sv
// Wishbone classic-cycle memory slave: programmable ack latency, address window decode, saturating access counters.
// Optional feature macro: T08_WB_MEM_ERR_EN (out-of-window accesses answered with err instead of ack).
module t08_wb_mem_slave #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DATA_W-1:0]   wbs_dat_i,
    output logic [DATA_W-1:0]   wbs_dat_o,
    output logic                wbs_ack_o,
    output logic                wbs_err_o,
    output logic [15:0]         rd_count_o,
    output logic [15:0]         wr_count_o
);
    localparam int          SEL_W     = DATA_W / 8;
    localparam int          BYTE_SH   = $clog2(SEL_W);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] WIN_BYTES = 33'(longint'(DEPTH) * longint'(SEL_W));
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
`ifdef T08_WB_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [31:0]       adr_reg, adr_next;
    logic              we_reg, we_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [DATA_W-1:0] dat_reg, dat_next;
    logic              ack_reg, err_reg;
    logic [15:0]       rd_count_reg, wr_count_reg;
    logic              resp;

    // Decode works on the latched request so it is stable for the whole transfer.
    logic [31:0]   offset;
    logic          in_window;
    logic [AW-1:0] word_idx;
    assign offset    = adr_reg - BASE_ADDR;
    assign in_window = (adr_reg >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    assign word_idx  = AW'(offset >> BYTE_SH);

    logic do_ack, do_err, mem_wr_en, rd_load;
    assign do_ack    = resp && (in_window || !ERR_EN);
    assign do_err    = resp && !in_window && ERR_EN;
    assign mem_wr_en = resp && we_reg && in_window;
    assign rd_load   = resp && !we_reg && (in_window || !ERR_EN);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        adr_next   = adr_reg;
        we_next    = we_reg;
        sel_next   = sel_reg;
        dat_next   = dat_reg;
        resp       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_next   = wbs_adr_i;
                    we_next    = wbs_we_i;
                    sel_next   = wbs_sel_i;
                    dat_next   = wbs_dat_i;
                    cnt_next   = WAIT_LD;
                    state_next = (WAIT_LD != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // Master dropping cyc abandons the transfer without side effects.
                if (!wbs_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) state_next = RESP;
                end
            end
            RESP: begin
                resp       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            adr_reg      <= '0;
            we_reg       <= 1'b0;
            sel_reg      <= '0;
            dat_reg      <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            adr_reg   <= adr_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
            dat_reg   <= dat_next;
            ack_reg   <= do_ack;
            err_reg   <= do_err;
            if (do_ack && we_reg && (wr_count_reg != 16'hFFFF))
                wr_count_reg <= wr_count_reg + 16'd1;
            if (do_ack && !we_reg && (rd_count_reg != 16'hFFFF))
                rd_count_reg <= rd_count_reg + 16'd1;
        end
    end

    // One byte-wide RAM per lane gives byte-enable writes with a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge wb_clk_i) begin
                if (mem_wr_en && sel_reg[gi])
                    lane_mem[word_idx] <= dat_reg[8*gi +: 8];
            end

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i)
                    lane_q_reg <= 8'h00;
                else if (rd_load)
                    lane_q_reg <= in_window ? lane_mem[word_idx] : 8'h00;
            end

            assign wbs_dat_o[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    assign wbs_ack_o  = ack_reg;
    assign wbs_err_o  = err_reg;
    assign rd_count_o = rd_count_reg;
    assign wr_count_o = wr_count_reg;
endmodule
